// File: rtl/cpu_test_pkg.sv
// Shared types for the cpu result checker: FSM states, checkpoint slot layout
// and the index-width helper used to size slot selectors.
package cpu_test_pkg;

  // Slot fields are sized for the widest supported CPU; narrower values are zero-extended.
  localparam int unsigned SLOT_VAL_W = 64;
  localparam int unsigned SLOT_REG_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic                  en;
    logic [SLOT_REG_W-1:0] addr;
    logic [SLOT_VAL_W-1:0] val;
  } slot_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_halt_detector.sv
// Flags the jump-to-self halt idiom: a pulse once pc has held one value for
// HALT_CYCLES consecutive enabled cycles.
module cpu_halt_detector #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] pc,
  output logic             halt
);

  localparam int unsigned CNT_W = (HALT_CYCLES <= 2) ? 1 : $clog2(HALT_CYCLES);
  localparam logic [CNT_W-1:0] HALT_AT = CNT_W'(HALT_CYCLES - 2);

  logic [WIDTH-1:0] prev_pc;
  logic             prev_valid;
  logic [CNT_W-1:0] stable;
  logic             same;

  assign same = prev_valid && (pc == prev_pc);
  // Fires on the cycle whose edge would take the stable count to HALT_CYCLES-1.
  assign halt = en && same && (stable == HALT_AT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stable     <= '0;
    end else if (clear) begin
      prev_valid <= 1'b0;
      stable     <= '0;
    end else if (en) begin
      prev_pc    <= pc;
      prev_valid <= 1'b1;
      if (!same) begin
        stable <= '0;
      end else if (stable != HALT_AT) begin
        stable <= stable + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_result_checker.sv
// Completion monitor for the single-cycle cpu: snoops writeback into per-slot
// shadows, waits for a PC halt or timeout, then compares each checkpoint.
module cpu_result_checker
  import cpu_test_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned NUM_CHECKS  = 4,
  parameter int unsigned IDX_W       = idx_width(NUM_CHECKS),
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [REG_ADDR_W-1:0] cfg_reg,
  input  logic [WIDTH-1:0]      cfg_val,
  input  logic [WIDTH-1:0]      pc,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  passed,
  output logic                  timed_out,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [WIDTH-1:0]      fail_got,
  output logic [TIMEOUT_W-1:0]  cycle_count
);

  state_t               state, state_next;
  slot_t                slots  [NUM_CHECKS];
  logic [WIDTH-1:0]     shadow [NUM_CHECKS];
  logic [TIMEOUT_W-1:0] limit;
  logic [IDX_W-1:0]     check_idx;
  logic                 mismatch_seen;
  logic                 halt, idle_or_done, start_ok, cfg_ok;
  logic                 timeout_hit, last_check, cur_mismatch;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign start_ok     = start && idle_or_done;
  assign cfg_ok       = cfg_we && idle_or_done && (32'(cfg_idx) < NUM_CHECKS);
  assign timeout_hit  = (cycle_count == limit);
  assign last_check   = (check_idx == IDX_W'(NUM_CHECKS - 1));
  assign cur_mismatch = slots[check_idx].en &&
                        (slots[check_idx].val != SLOT_VAL_W'(shadow[check_idx]));

  cpu_halt_detector #(
    .WIDTH       (WIDTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_ok),
    .en      (state == RUN),
    .pc      (pc),
    .halt    (halt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        // Halt takes priority over a coincident timeout.
        if (halt)             state_next = CHECK;
        else if (timeout_hit) state_next = DONE;
      end
      CHECK: begin
        busy = 1'b1;
        if (last_check) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        slots[i]  <= '0;
        shadow[i] <= '0;
      end
      limit         <= '0;
      check_idx     <= '0;
      mismatch_seen <= 1'b0;
      passed        <= 1'b0;
      timed_out     <= 1'b0;
      fail_idx      <= '0;
      fail_got      <= '0;
      cycle_count   <= '0;
    end else begin
      // A config write colliding with start lands first, so the new run sees it.
      if (cfg_ok) begin
        slots[cfg_idx] <= '{en: cfg_en, addr: SLOT_REG_W'(cfg_reg), val: SLOT_VAL_W'(cfg_val)};
      end
      if (start_ok) begin
        for (int unsigned i = 0; i < NUM_CHECKS; i++) shadow[i] <= '0;
        limit         <= timeout_limit;
        check_idx     <= '0;
        mismatch_seen <= 1'b0;
        passed        <= 1'b0;
        timed_out     <= 1'b0;
        fail_idx      <= '0;
        fail_got      <= '0;
        cycle_count   <= '0;
      end else if (state == RUN) begin
        if (timeout_hit && !halt) begin
          timed_out <= 1'b1;
        end else if (cycle_count != '1) begin
          cycle_count <= cycle_count + TIMEOUT_W'(1);
        end
        for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
          if (wb_en && (wb_addr != '0) && (SLOT_REG_W'(wb_addr) == slots[i].addr)) begin
            shadow[i] <= wb_data;
          end
        end
      end else if (state == CHECK) begin
        check_idx <= check_idx + IDX_W'(1);
        if (cur_mismatch && !mismatch_seen) begin
          mismatch_seen <= 1'b1;
          fail_idx      <= check_idx;
          fail_got      <= shadow[check_idx];
        end
        if (last_check) passed <= !(mismatch_seen || cur_mismatch);
      end
    end
  end

endmodule

// File: tb/tb_cpu_result_checker.sv
// Scoreboard bench for cpu_result_checker: directed runs push expected results,
// a negedge monitor pops and compares whenever done rises.
module tb_cpu_result_checker;

  localparam int unsigned NC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] timeout_limit = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic        cfg_en = 1'b0;
  logic [4:0]  cfg_reg = '0;
  logic [31:0] cfg_val = '0;
  logic [31:0] pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        busy, done, passed, timed_out;
  logic [1:0]  fail_idx;
  logic [31:0] fail_got;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] passed, timed_out, fail_idx, fail_got, cc, done_cyc;
  } exp_t;
  exp_t q[$];

  cpu_result_checker #(
    .WIDTH       (32),
    .REG_ADDR_W  (5),
    .NUM_CHECKS  (NC),
    .TIMEOUT_W   (16),
    .HALT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .timeout_limit (timeout_limit),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_en        (cfg_en),
    .cfg_reg       (cfg_reg),
    .cfg_val       (cfg_val),
    .pc            (pc),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .busy          (busy),
    .done          (done),
    .passed        (passed),
    .timed_out     (timed_out),
    .fail_idx      (fail_idx),
    .fail_got      (fail_got),
    .cycle_count   (cycle_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin : monitor
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 required no pending run");
        end else begin
          e = q.pop_front();
          chk("passed",      64'(passed),      e.passed);
          chk("timed_out",   64'(timed_out),   e.timed_out);
          chk("fail_idx",    64'(fail_idx),    e.fail_idx);
          chk("fail_got",    64'(fail_got),    e.fail_got);
          chk("cycle_count", 64'(cycle_count), e.cc);
          chk("done_cycle",  64'(cyc),         e.done_cyc);
        end
      end
      done_q = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic we, input logic [4:0] a, input logic [31:0] d);
    pc = p; wb_en = we; wb_addr = a; wb_data = d;
    step();
  endtask

  task automatic hold(input logic [31:0] p, input int n);
    repeat (n) drive(p, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic en, input logic [4:0] r, input logic [31:0] v);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_reg = r; cfg_val = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] lim);
    start = 1'b1; timeout_limit = lim;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      step();
      k++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_wait: got done=0 required done=1 within 40 cycles");
    end
    step();
  endtask

  // Called right after the last RUN cycle's edge; halted runs finish NC cycles later.
  task automatic expect_run(input logic [63:0] p, input logic [63:0] to, input logic [63:0] fi,
                            input logic [63:0] fg, input logic [63:0] cc, input bit halted);
    exp_t e;
    e.passed = p; e.timed_out = to; e.fail_idx = fi; e.fail_got = fg; e.cc = cc;
    e.done_cyc = 64'(cyc) + (halted ? 64'(NC) : 64'd0);
    q.push_back(e);
    wait_done();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Garbage on every input, then reset mid-cycle
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b1;
    cfg_reg = 5'($urandom); cfg_val = $urandom | 32'h1; timeout_limit = '1; wb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = $urandom; wb_addr = 5'($urandom); wb_data = $urandom;
      step();
    end
    chk("garbage_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy",        64'(busy),        64'd0);
    chk("rst_done",        64'(done),        64'd0);
    chk("rst_passed",      64'(passed),      64'd0);
    chk("rst_timed_out",   64'(timed_out),   64'd0);
    chk("rst_fail_idx",    64'(fail_idx),    64'd0);
    chk("rst_fail_got",    64'(fail_got),    64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    step();
    start = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0; cfg_reg = '0; cfg_val = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; pc = '0;
    reset_n = 1'b1;
    step();

    // Simple program: reg2 ends at 4
    cfg(2'd0, 1'b1, 5'd2, 32'd4);
    start_run(16'd1000);
    drive(32'h0, 1'b1, 5'd2, 32'd3);
    drive(32'h4, 1'b1, 5'd2, 32'd4);
    hold(32'h8, 4);
    expect_run(1, 0, 0, 0, 6, 1'b1);

    // Two mismatches: only the first is reported
    cfg(2'd0, 1'b0, 5'd0, 32'd0);
    cfg(2'd1, 1'b1, 5'd3, 32'd58);
    cfg(2'd3, 1'b1, 5'd5, 32'd270);
    start_run(16'd1000);
    drive(32'h0, 1'b1, 5'd3, 32'd55);
    drive(32'h4, 1'b1, 5'd5, 32'd1);
    hold(32'h8, 4);
    expect_run(0, 0, 1, 55, 6, 1'b1);

    // Timeout with an ever-changing pc
    start_run(16'd10);
    for (int i = 0; i <= 10; i++) drive(32'(4 * i), 1'b0, 5'd0, 32'd0);
    expect_run(0, 1, 0, 0, 10, 1'b0);

    // Halt coincides with timeout; shadows restart from 0
    start_run(16'd3);
    hold(32'h8, 4);
    expect_run(0, 0, 1, 0, 4, 1'b1);

    // Writes to reg 0 are dropped
    cfg(2'd0, 1'b1, 5'd0, 32'd0);
    cfg(2'd1, 1'b0, 5'd0, 32'd0);
    cfg(2'd3, 1'b0, 5'd0, 32'd0);
    start_run(16'd1000);
    drive(32'h0, 1'b1, 5'd0, 32'hDEAD);
    hold(32'h8, 4);
    expect_run(1, 0, 0, 0, 5, 1'b1);

    // Two stretches of HALT_CYCLES-1 stable pc never halt
    start_run(16'd12);
    drive(32'h0, 1'b0, 5'd0, 32'd0);
    hold(32'h8, 3);
    hold(32'd200, 3);
    for (int i = 7; i <= 12; i++) drive(32'(300 + 4 * i), 1'b0, 5'd0, 32'd0);
    expect_run(0, 1, 0, 0, 12, 1'b0);

    // start and cfg_we during RUN are ignored
    cfg(2'd0, 1'b1, 5'd7, 32'd9);
    start_run(16'd1000);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_reg = 5'd7; cfg_val = 32'd99;
    drive(32'h0, 1'b1, 5'd7, 32'd9);
    start = 1'b0; cfg_we = 1'b0;
    hold(32'h8, 4);
    expect_run(1, 0, 0, 0, 5, 1'b1);

    // start + cfg_we in DONE: new slot value governs the run
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_reg = 5'd7; cfg_val = 32'd5;
    timeout_limit = 16'd1000;
    step();
    start = 1'b0; cfg_we = 1'b0;
    drive(32'h0, 1'b1, 5'd7, 32'd5);
    hold(32'h8, 4);
    expect_run(1, 0, 0, 0, 5, 1'b1);

    // Reset during CHECK, then a rerun with an empty table
    start_run(16'd1000);
    drive(32'h0, 1'b1, 5'd7, 32'd6);
    hold(32'h8, 4);
    step();
    chk("check_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(busy),        64'd0);
    chk("midrst_done",  64'(done),        64'd0);
    chk("midrst_count", 64'(cycle_count), 64'd0);
    #3 reset_n = 1'b1;
    step();
    start_run(16'd1000);
    drive(32'h0, 1'b1, 5'd7, 32'd6);
    hold(32'h8, 4);
    expect_run(1, 0, 0, 0, 5, 1'b1);

    repeat (3) step();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_result_checker.md
Name: cpu_result_checker

Overview:
Synthesizable, self-checking completion monitor that sits beside the single-cycle cpu and snoops its PC and register-file writeback port. It replaces the fixed-delay, single-register testbench check with several programmable (register, expected value) checkpoints. It detects program end as a stalled PC (the jump-to-self halt idiom), enforces a cycle timeout, and reports pass/fail with first-failure diagnostics. Intended for FPGA bring-up and for reuse across the simple/fib/hanoi program images.

Parameters:
WIDTH, 32, data and PC width
REG_ADDR_W, 5, register-file address width
NUM_CHECKS, 4, number of checkpoint slots (>=1)
IDX_W, $clog2(NUM_CHECKS) (min 1), checkpoint index width
TIMEOUT_W, 16, cycle counter and timeout width
HALT_CYCLES, 4, consecutive equal-PC cycles that count as a halt (>=2)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a run (honoured only in IDLE or DONE)
timeout_limit  in  TIMEOUT_W  max cycles in RUN; sampled on start
cfg_we  in  1  write one checkpoint slot (honoured only in IDLE or DONE)
cfg_idx  in  IDX_W  slot to write
cfg_en  in  1  slot enable
cfg_reg  in  REG_ADDR_W  register to check
cfg_val  in  WIDTH  expected value
pc  in  WIDTH  cpu current PC
wb_en  in  1  cpu register write enable
wb_addr  in  REG_ADDR_W  cpu write address
wb_data  in  WIDTH  cpu write data
busy  out  1  high in RUN or CHECK
done  out  1  high in DONE
passed  out  1  valid when done
timed_out  out  1  valid when done
fail_idx  out  IDX_W  first failing slot
fail_got  out  WIDTH  value observed in first failing slot
cycle_count  out  TIMEOUT_W  cycles spent in RUN

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; all slot enables, regs, vals and shadows 0; cycle_count 0.
- States: IDLE -> RUN on start; RUN -> CHECK on halt; RUN -> DONE on timeout; CHECK -> DONE after slot NUM_CHECKS-1; DONE -> RUN on start.
- On start: cycle_count, shadows, halt counter, passed, timed_out, fail_idx and fail_got cleared; timeout_limit latched.
- RUN: cycle_count increments every cycle. Each slot's shadow captures wb_data whenever wb_en=1 and wb_addr==slot reg; writes to reg 0 are ignored (shadow stays 0).
- Halt: stable counter increments when pc equals the previous cycle's pc, else resets to 0. Halt occurs when the counter reaches HALT_CYCLES-1. The first RUN cycle has no previous pc and never counts.
- Timeout: occurs when cycle_count equals the latched limit at a rising edge. A limit of 0 times out on the first RUN cycle. Halt and timeout in the same cycle: halt wins.
- Shadows freeze on leaving RUN; wb activity during CHECK or DONE is ignored.
- CHECK: one slot per cycle, index 0 upward; NUM_CHECKS cycles total. Disabled slots pass. The first mismatch records fail_idx and fail_got; later mismatches do not overwrite them.
- DONE is entered the cycle after the last compare:
  - passed=1 iff no mismatch and not timed out.
  - Timeout path: timed_out=1, passed=0, fail_idx=0, fail_got=0.
  - Outputs hold until the next start. No enabled slots plus a halt gives passed=1.
- start, cfg_we or a start/cfg_we collision in RUN/CHECK is ignored. A start/cfg_we collision in IDLE/DONE: the config write is applied, then the run starts with the new slot.
- cycle_count saturates at all-ones.
- Reset mid-run: immediate return to IDLE with the slot table cleared.

Decomposition:
- Package cpu_test_pkg: state enum (IDLE, RUN, CHECK, DONE), checkpoint slot struct {en, reg, val}, index-width function.
- Sub-module cpu_halt_detector (pc register plus stable counter, params WIDTH and HALT_CYCLES, outputs halt pulse), instantiated once.

Test Plan:
- Reset: drive all inputs to garbage, assert reset_n low mid-cycle -> all outputs 0 immediately, state IDLE.
- Simple program: slot0 = {en=1, reg=2, val=4}; start; write reg2=3 then reg2=4; pc=0x8 constant for 4 cycles -> done, passed=1, timed_out=0, done exactly NUM_CHECKS cycles after halt detection.
- Mismatch ordering: slot1 = {reg 3, val 58}, slot3 = {reg 5, val 270}; observe reg3=55, reg5=1 -> passed=0, fail_idx=1, fail_got=55.
- Timeout: timeout_limit=10, pc increments every cycle -> done with timed_out=1, passed=0, cycle_count=10.
- Boundaries:
  - Halt and timeout in the same cycle -> CHECK path taken, timed_out=0.
  - Writes to reg 0 with val 0 -> slot passes.
  - pc stable for only HALT_CYCLES-1 cycles, then changes -> no halt.
- Ignored controls: cfg_we and start during RUN -> table and run unaffected. Reset in CHECK -> IDLE, and a rerun with no slots enabled yields passed=1.
